// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int MEM_BYTES_DEF = 128;
  localparam int DW_BYTES      = 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_rr_picker.sv
// Grant selection between the two requesters. Round-robin with a last-grant
// pointer when DMEM_ARB_RR_EN is defined, fixed priority (port 0) otherwise.
module dmem_rr_picker
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic grant
);

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  // NOTE: every output of an always_comb gets a default first so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant = PORT0;
    if (req0 && req1) grant = ~last_q;
    else if (req1)    grant = PORT1;
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         last_q <= PORT1;
    else if (grant_en) last_q <= grant;
  end
`else
  assign grant = req0 ? PORT0 : PORT1;

  logic unused_pins;
  assign unused_pins = ^{clk, reset, grant_en};
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the 64-bit DATA_Memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - DW_BYTES);

  state_t state_q, state_d;

  logic              start;
  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              lat_we;
  logic              lat_port;
  logic              lat_err;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  logic in_access;
  logic in_resp;

  assign start = (state_q == ST_IDLE) && (p0_req || p1_req);

  dmem_rr_picker u_picker (
    .clk      (clk),
    .reset    (reset),
    .req0     (p0_req),
    .req1     (p1_req),
    .grant_en (start),
    .grant    (grant)
  );

  assign sel_we    = (grant == PORT0) ? p0_we    : p1_we;
  assign sel_addr  = (grant == PORT0) ? p0_addr  : p1_addr;
  assign sel_wdata = (grant == PORT0) ? p0_wdata : p1_wdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the request latch and response data carry no reset; they are only
  // observed while the FSM qualifies them, and the FSM itself is reset.
  always_ff @(posedge clk) begin
    if (start) begin
      lat_we    <= sel_we;
      lat_port  <= grant;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
      lat_err   <= (sel_addr > LAST_ADDR);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_ACCESS) begin
      rsp_err   <= lat_err;
      rsp_rdata <= (lat_we || lat_err) ? '0 : mem_read_data;
    end
  end

  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);

  // An out-of-range access keeps both strobes low but still spends its cycle.
  assign mem_address   = in_access ? lat_addr  : '0;
  assign mem_writeData = in_access ? lat_wdata : '0;
  assign mem_MemRead   = in_access && !lat_err && !lat_we;
  assign mem_MemWrite  = in_access && !lat_err &&  lat_we;

  assign p0_ack   = in_resp && (lat_port == PORT0);
  assign p1_ack   = in_resp && (lat_port == PORT1);
  assign p0_rdata = p0_ack ? rsp_rdata : '0;
  assign p1_rdata = p1_ack ? rsp_rdata : '0;
  assign p0_err   = p0_ack && rsp_err;
  assign p1_err   = p1_ack && rsp_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised self-checking bench for dmem_arbiter with a byte-array memory and
// a transaction-level reference model (ack order equals execution order).
module tb_dmem_arbiter;

  localparam int MB     = 128;
  localparam int LAST   = MB - 8;
  localparam int BUDGET = 24;

  logic clk = 1'b0;
  logic reset;
  logic init_mem;

  logic        req   [2];
  logic        we    [2];
  logic [63:0] addr  [2];
  logic [63:0] wdata [2];

  logic        p0_ack, p1_ack, p0_err, p1_err;
  logic [63:0] p0_rdata, p1_rdata;
  logic [63:0] mem_address, mem_writeData, mem_read_data;
  logic        mem_MemRead, mem_MemWrite;

  logic [7:0] mem     [MB];
  logic [7:0] ref_mem [MB];

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;
  int ack_count   = 0;
  int issue_count = 0;

  bit          busy     [2];
  bit          hold     [2];
  int          cool     [2];
  int          wait_cyc [2];
  int          last_lat [2];
  logic [63:0] last_rdata [2];
  logic        last_err   [2];
  logic        ref_last;
  int          ack_log [$];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .p0_req        (req[0]),
    .p0_we         (we[0]),
    .p0_addr       (addr[0]),
    .p0_wdata      (wdata[0]),
    .p0_ack        (p0_ack),
    .p0_rdata      (p0_rdata),
    .p0_err        (p0_err),
    .p1_req        (req[1]),
    .p1_we         (we[1]),
    .p1_addr       (addr[1]),
    .p1_wdata      (wdata[1]),
    .p1_ack        (p1_ack),
    .p1_rdata      (p1_rdata),
    .p1_err        (p1_err),
    .mem_address   (mem_address),
    .mem_writeData (mem_writeData),
    .mem_MemRead   (mem_MemRead),
    .mem_MemWrite  (mem_MemWrite),
    .mem_read_data (mem_read_data)
  );

  // Data memory: combinational read, write on the rising edge.
  always_comb begin
    mem_read_data = '0;
    if (mem_address <= 64'(LAST))
      for (int i = 0; i < 8; i++) mem_read_data[8*i +: 8] = mem[int'(mem_address) + i];
  end

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < MB; i++) mem[i] <= 8'(i + 1);
    end else if (mem_MemWrite && mem_address <= 64'(LAST)) begin
      for (int i = 0; i < 8; i++) mem[int'(mem_address) + i] <= mem_writeData[8*i +: 8];
    end
  end

  // Protocol invariants observed every cycle.
  always @(negedge clk) begin
    if (mem_MemRead && mem_MemWrite) viol++;
    if (mem_MemWrite && mem_address > 64'(LAST)) viol++;
    if (!p0_ack && (p0_rdata != '0 || p0_err)) viol++;
    if (!p1_ack && (p1_rdata != '0 || p1_err)) viol++;
    if (p0_ack && p1_ack) viol++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[int'(a) + i];
    return r;
  endfunction

  task automatic issue(input int p, input logic w, input logic [63:0] a, input logic [63:0] d);
    we[p]       = w;
    addr[p]     = a;
    wdata[p]    = d;
    req[p]      = 1'b1;
    busy[p]     = 1'b1;
    wait_cyc[p] = 0;
    issue_count++;
  endtask

  // Advance one cycle, then score any ack against the reference model.
  task automatic step();
    logic        ack_v [2];
    logic [63:0] rd_v  [2];
    logic        err_v [2];
    logic        oor;
    logic [63:0] exp;
    @(negedge clk);
    ack_v[0] = p0_ack;   ack_v[1] = p1_ack;
    rd_v[0]  = p0_rdata; rd_v[1]  = p1_rdata;
    err_v[0] = p0_err;   err_v[1] = p1_err;
    for (int p = 0; p < 2; p++) begin
      if (cool[p] > 0) cool[p]--;
      if (ack_v[p]) begin
        ack_log.push_back(p);
        ack_count++;
        ref_last = 1'(p);
        if (!busy[p]) begin
          check($sformatf("spurious_ack_p%0d", p), 64'(ack_v[p]), 64'(busy[p]));
        end else begin
          oor = (addr[p] > 64'(LAST));
          exp = (we[p] || oor) ? 64'h0 : ref_read(addr[p]);
          check($sformatf("rdata_p%0d", p), rd_v[p], exp);
          check($sformatf("err_p%0d", p), 64'(err_v[p]), 64'(oor));
          if (we[p] && !oor)
            for (int i = 0; i < 8; i++) ref_mem[int'(addr[p]) + i] = wdata[p][8*i +: 8];
          last_lat[p]   = wait_cyc[p] + 1;
          last_rdata[p] = rd_v[p];
          last_err[p]   = err_v[p];
          wait_cyc[p]   = 0;
          if (!hold[p]) begin
            req[p]  = 1'b0;
            busy[p] = 1'b0;
            cool[p] = 2;
          end
        end
      end else if (busy[p]) begin
        wait_cyc[p]++;
        if (wait_cyc[p] > BUDGET) begin
          check($sformatf("timeout_p%0d", p), 64'(wait_cyc[p]), 64'(BUDGET));
          req[p]  = 1'b0;
          busy[p] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * BUDGET && (busy[0] || busy[1]); k++) step();
  endtask

  initial begin
    logic [63:0] a;
    int          ack0, iss0;
    logic        prev, exp_port;

    reset = 1'b1;
    init_mem = 1'b1;
    ref_last = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
      busy[p] = 1'b0; hold[p] = 1'b0; cool[p] = 0; wait_cyc[p] = 0;
    end
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'(i + 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_flags", {58'h0, p0_ack, p1_ack, p0_err, p1_err, mem_MemRead, mem_MemWrite}, 64'h0);
    check("rst_rdata", p0_rdata | p1_rdata, 64'h0);
    check("rst_bus", mem_address | mem_writeData, 64'h0);
    reset = 1'b0;
    init_mem = 1'b0;

    // Read after reset, with exact latency.
    issue(0, 1'b0, 64'd0, 64'h0);
    step();
    check("rd0_access_strobe", 64'(mem_MemRead), 64'h1);
    drain();
    check("rd0_latency", 64'(last_lat[0]), 64'd2);
    check("rd0_value", last_rdata[0], 64'h0807060504030201);

    // Write then read back; neighbour doubleword untouched.
    issue(1, 1'b1, 64'd16, 64'hDEADBEEFCAFEF00D);
    drain();
    issue(1, 1'b0, 64'd16, 64'h0);
    drain();
    check("wr_rd_value", last_rdata[1], 64'hDEADBEEFCAFEF00D);
    issue(0, 1'b0, 64'd24, 64'h0);
    drain();
    check("neighbour_value", last_rdata[0], 64'h201F1E1D1C1B1A19);

    // Out-of-range write, then the last legal doubleword.
    issue(0, 1'b1, 64'd121, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("oor_no_write", 64'(mem_MemWrite), 64'h0);
    drain();
    check("oor_err", 64'(last_err[0]), 64'h1);
    check("oor_rdata", last_rdata[0], 64'h0);
    issue(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1234);
    drain();
    check("wrap_err", 64'(last_err[1]), 64'h1);
    issue(0, 1'b0, 64'd120, 64'h0);
    drain();
    check("top_value", last_rdata[0], 64'h807F7E7D7C7B7A79);

    // Both ports held continuously: arbitration order.
    repeat (3) step();
    ack_log.delete();
    prev = ref_last;
    hold[0] = 1'b1;
    hold[1] = 1'b1;
    issue(0, 1'b0, 64'd0, 64'h0);
    issue(1, 1'b0, 64'd8, 64'h0);
    repeat (12) step();
    check("tie_ack_count", 64'(ack_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < ack_log.size(); k++) begin
`ifdef DMEM_ARB_RR_EN
      exp_port = ~prev;
`else
      exp_port = 1'b0;
`endif
      check($sformatf("tie_grant_%0d", k), 64'(ack_log[k]), 64'(exp_port));
      prev = exp_port;
    end
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    drain();
    repeat (3) step();

    // Reset during ACCESS aborts the read with no ack.
    issue(0, 1'b0, 64'd8, 64'h0);
    step();
    check("mid_access_strobe", 64'(mem_MemRead), 64'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_flags", {58'h0, p0_ack, p1_ack, p0_err, p1_err, mem_MemRead, mem_MemWrite}, 64'h0);
    check("mid_rst_bus", mem_address | mem_writeData | p0_rdata | p1_rdata, 64'h0);
    req[0]  = 1'b0;
    busy[0] = 1'b0;
    ref_last = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ack0 = ack_count;
    repeat (4) step();
    check("mid_rst_no_ack", 64'(ack_count - ack0), 64'h0);
    issue(0, 1'b0, 64'd8, 64'h0);
    drain();
    check("post_rst_latency", 64'(last_lat[0]), 64'd2);
    check("post_rst_value", last_rdata[0], 64'h100F0E0D0C0B0A09);

    // Random traffic on both ports.
    ack0 = ack_count;
    iss0 = issue_count;
    for (int c = 0; c < 400; c++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (!busy[p] && cool[p] == 0 && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 7))
            0:       a = 64'(121 + $urandom_range(0, 14));
            1:       a = {32'hFFFF_FFFF, 32'($urandom)};
            default: a = 64'($urandom_range(0, LAST));
          endcase
          issue(p, 1'($urandom_range(0, 1)), a, {32'($urandom), 32'($urandom)});
        end
      end
    end
    drain();
    check("rand_ack_count", 64'(ack_count - ack0), 64'(issue_count - iss0));
    check("monitor_violations", 64'(viol), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
